// File: rtl/inertial_integrator.sv
// Pitch estimator: calibrates the gyro rate offset, then runs a complementary filter that
// integrates the compensated rate and nudges the result toward the accelerometer pitch.
module inertial_integrator #(
  parameter int unsigned CAL_LOG2  = 4,
  parameter logic [15:0] AZ_OFFSET = 16'h00A0,
  parameter int          FUSION    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  input  logic               clr,
  input  logic               recal,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               ptch_vld,
  output logic               cal_done
);

  localparam int unsigned         SumW    = 16 + CAL_LOG2;
  localparam logic [CAL_LOG2-1:0] CntLast = {CAL_LOG2{1'b1}};
  localparam logic signed [28:0]  FusMag  = 29'(FUSION);
  localparam logic signed [26:0]  IntMax  = 27'h3FFFFFF;
  localparam logic signed [26:0]  IntMin  = 27'h4000000;

  typedef enum logic [0:0] {StCal, StRun} state_e;

  state_e                   state_q;
  logic [CAL_LOG2-1:0]      cnt_q;
  logic signed [SumW-1:0]   cal_sum_q;
  logic signed [SumW-1:0]   cal_sum_nxt;
  logic signed [SumW-1:0]   cal_avg;
  logic signed [15:0]       rt_off_q;
  logic signed [15:0]       rt_comp;
  logic signed [15:0]       az_comp;
  logic signed [25:0]       az_ext;
  logic signed [25:0]       prod;
  logic signed [15:0]       ptch_acc;
  logic signed [28:0]       fus;
  logic signed [28:0]       int_sum;
  logic signed [26:0]       ptch_int_q;
  logic signed [26:0]       ptch_int_nxt;
  logic signed [15:0]       ptch_rt_q;
  logic                     ptch_vld_q;
  logic                     cal_done_q;
  logic                     unused_bits;

  assign ptch     = ptch_int_q[26:11];
  assign ptch_rt  = ptch_rt_q;
  assign ptch_vld = ptch_vld_q;
  assign cal_done = cal_done_q;

  always_comb begin
    cal_sum_nxt = cal_sum_q + {{CAL_LOG2{ptch_rt_raw[15]}}, ptch_rt_raw};
    cal_avg     = cal_sum_nxt >>> CAL_LOG2;
    rt_comp     = ptch_rt_raw - rt_off_q;
    az_comp     = AZ - $signed(AZ_OFFSET);
    az_ext      = {{10{az_comp[15]}}, az_comp};
    prod        = az_ext * 26'sd327;
    ptch_acc    = {{3{prod[25]}}, prod[25:13]};
    fus         = (ptch_acc > ptch) ? FusMag : -FusMag;
    int_sum     = {{2{ptch_int_q[26]}}, ptch_int_q} - {{13{rt_comp[15]}}, rt_comp} + fus;
    // Clamp when the two guard bits disagree with the 27-bit sign.
    if (int_sum[28:26] == 3'b000 || int_sum[28:26] == 3'b111) begin
      ptch_int_nxt = int_sum[26:0];
    end else begin
      ptch_int_nxt = int_sum[28] ? IntMin : IntMax;
    end
  end

  assign unused_bits = ^{prod[12:0], cal_avg[SumW-1:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCal;
      cnt_q      <= '0;
      cal_sum_q  <= '0;
      rt_off_q   <= '0;
      ptch_int_q <= '0;
      ptch_rt_q  <= '0;
      ptch_vld_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      ptch_vld_q <= 1'b0;
      if (recal) begin
        // Offset and integrator are kept until the new calibration completes.
        state_q    <= StCal;
        cal_done_q <= 1'b0;
        cnt_q      <= '0;
        cal_sum_q  <= '0;
      end else if (clr) begin
        ptch_int_q <= '0;
      end else if (vld) begin
        unique case (state_q)
          StCal: begin
            if (cnt_q == CntLast) begin
              rt_off_q   <= cal_avg[15:0];
              cnt_q      <= '0;
              cal_sum_q  <= '0;
              state_q    <= StRun;
              cal_done_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_q + CAL_LOG2'(1);
              cal_sum_q <= cal_sum_nxt;
            end
          end
          StRun: begin
            ptch_int_q <= ptch_int_nxt;
            ptch_rt_q  <= rt_comp;
            ptch_vld_q <= 1'b1;
          end
          default: state_q <= StCal;
        endcase
      end
    end
  end

endmodule
